// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between four processors, the memory arbiter and the memory
// subsystem. The arbiter uses the master modport: it drives the memory
// request bus and the per-processor responses. The environment (processors
// plus memory) uses the slave modport.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  // Processor side
  logic [3:0]             proc_req;
  logic [3:0]             proc_we;
  logic [3:0][ADDR_W-1:0] proc_addr;
  logic [3:0][DATA_W-1:0] proc_wdata;
  logic [3:0]             proc_done;
  logic [3:0]             proc_err;
  logic [DATA_W-1:0]      proc_rdata;

  // Memory side
  logic                   mem_read_req;
  logic                   mem_write_req;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_write_data;
  logic [DATA_W-1:0]      mem_read_data;
  logic                   mem_ack;

  modport master (
    input  proc_req, proc_we, proc_addr, proc_wdata,
    output proc_done, proc_err, proc_rdata,
    output mem_read_req, mem_write_req, mem_addr, mem_write_data,
    input  mem_read_data, mem_ack
  );

  modport slave (
    output proc_req, proc_we, proc_addr, proc_wdata,
    input  proc_done, proc_err, proc_rdata,
    input  mem_read_req, mem_write_req, mem_addr, mem_write_data,
    output mem_read_data, mem_ack
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter granting one of four processors access to a single
// memory port. One transaction is outstanding at a time; a transaction that
// sees no mem_ack within TIMEOUT cycles is aborted with an error pulse.
// All outputs are registered.
module mem_req_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  mem_req_arbiter_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       last_grant;
  logic [1:0]       grant;
  logic             we_latched;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       winner;

  // Scan upward from last_grant+1; iterating from the farthest offset down
  // lets the nearest requester overwrite earlier candidates.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] g);
    onehot = 4'b0001 << g;
  endfunction

  // Combinational round-robin winner among current requests
  always_comb begin
    winner = rr_pick(bus.proc_req, last_grant);
  end

  // Arbitration FSM with registered memory-bus and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      last_grant         <= 2'd3;
      grant              <= 2'd0;
      we_latched         <= 1'b0;
      cnt                <= '0;
      bus.mem_read_req   <= 1'b0;
      bus.mem_write_req  <= 1'b0;
      bus.mem_addr       <= '0;
      bus.mem_write_data <= '0;
      bus.proc_done      <= 4'b0;
      bus.proc_err       <= 4'b0;
      bus.proc_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.proc_req) begin
            grant              <= winner;
            we_latched         <= bus.proc_we[winner];
            bus.mem_addr       <= bus.proc_addr[winner];
            bus.mem_write_data <= bus.proc_wdata[winner];
            bus.mem_read_req   <= ~bus.proc_we[winner];
            bus.mem_write_req  <= bus.proc_we[winner];
            cnt                <= '0;
            state              <= BUSY;
          end
        end

        BUSY: begin
          // An ack in the final timeout cycle still counts as completion.
          if (bus.mem_ack) begin
            bus.mem_read_req   <= 1'b0;
            bus.mem_write_req  <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            bus.proc_done      <= onehot(grant);
            bus.proc_rdata     <= we_latched ? '0 : bus.mem_read_data;
            state              <= RESP;
          end else if (cnt == CNT_LAST) begin
            bus.mem_read_req   <= 1'b0;
            bus.mem_write_req  <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            bus.proc_err       <= onehot(grant);
            bus.proc_rdata     <= '0;
            state              <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          bus.proc_done  <= 4'b0;
          bus.proc_err   <= 4'b0;
          bus.proc_rdata <= '0;
          last_grant     <= grant;
          state          <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: reset state, spurious ack, single
// read, write, round-robin rotation, timeout abort and reset mid-transaction.
module tb_mem_req_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic clk;
  logic reset;

  int n_chk;
  int n_pass;

  mem_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_req_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"},    64'(bus.mem_read_req),   64'h0);
    chk({tag, "_wr"},    64'(bus.mem_write_req),  64'h0);
    chk({tag, "_addr"},  64'(bus.mem_addr),       64'h0);
    chk({tag, "_done"},  64'(bus.proc_done),      64'h0);
    chk({tag, "_err"},   64'(bus.proc_err),       64'h0);
    chk({tag, "_rdata"}, 64'(bus.proc_rdata),     64'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    bus.proc_req      = 4'b0;
    bus.proc_we       = 4'b0;
    bus.proc_addr     = '0;
    bus.proc_wdata    = '0;
    bus.mem_read_data = '0;
    bus.mem_ack       = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk_quiet("reset");

    // Spurious ack in IDLE with no requests
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'hFFFF_FFFF;
    tick();
    bus.mem_ack = 1'b0;
    chk_quiet("spur1");
    tick();
    chk_quiet("spur2");

    // Single read, processor 0, ack at cycle 3
    bus.proc_addr[0] = 16'h0010;
    bus.proc_we      = 4'b0000;
    bus.proc_req     = 4'b0001;
    tick();                                   // cycle 1
    chk("rd_c1_rd",   64'(bus.mem_read_req),  64'h1);
    chk("rd_c1_wr",   64'(bus.mem_write_req), 64'h0);
    chk("rd_c1_addr", 64'(bus.mem_addr),      64'h0010);
    tick();                                   // cycle 2
    chk("rd_c2_rd",   64'(bus.mem_read_req),  64'h1);
    chk("rd_c2_done", 64'(bus.proc_done),     64'h0);
    tick();                                   // cycle 3
    chk("rd_c3_rd",   64'(bus.mem_read_req),  64'h1);
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'hDEAD_BEEF;
    tick();                                   // cycle 4
    bus.mem_ack  = 1'b0;
    bus.proc_req = 4'b0000;
    chk("rd_c4_rd",    64'(bus.mem_read_req), 64'h0);
    chk("rd_c4_done",  64'(bus.proc_done),    64'h1);
    chk("rd_c4_rdata", 64'(bus.proc_rdata),   64'hDEAD_BEEF);
    chk("rd_c4_err",   64'(bus.proc_err),     64'h0);
    tick();                                   // cycle 5, back in IDLE
    chk("rd_c5_done",  64'(bus.proc_done),    64'h0);
    chk("rd_c5_rdata", 64'(bus.proc_rdata),   64'h0);

    // Write, processor 2
    bus.proc_addr[2]  = 16'h00A0;
    bus.proc_wdata[2] = 32'h1234_5678;
    bus.proc_we       = 4'b0100;
    bus.proc_req      = 4'b0100;
    tick();
    chk("wr_wr",    64'(bus.mem_write_req),  64'h1);
    chk("wr_rd",    64'(bus.mem_read_req),   64'h0);
    chk("wr_addr",  64'(bus.mem_addr),       64'h00A0);
    chk("wr_wdata", 64'(bus.mem_write_data), 64'h1234_5678);
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'h5555_AAAA;
    tick();
    bus.mem_ack  = 1'b0;
    bus.proc_req = 4'b0000;
    bus.proc_we  = 4'b0000;
    chk("wr_done",  64'(bus.proc_done),     64'h4);
    chk("wr_rdata", 64'(bus.proc_rdata),    64'h0);
    chk("wr_off",   64'(bus.mem_write_req), 64'h0);
    tick();

    // Round-robin from reset: grants 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.proc_addr[i] = 16'(16'h0100 + i);
    end
    bus.proc_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();                                 // BUSY
      chk("rr_addr", 64'(bus.mem_addr),     64'(16'h0100 + (k % 4)));
      chk("rr_rd",   64'(bus.mem_read_req), 64'h1);
      bus.mem_ack       = 1'b1;
      bus.mem_read_data = 32'(32'hA000 + k);
      tick();                                 // RESP
      bus.mem_ack = 1'b0;
      chk("rr_done",  64'(bus.proc_done),  64'(4'b0001 << (k % 4)));
      chk("rr_rdata", 64'(bus.proc_rdata), 64'(32'hA000 + k));
      tick();                                 // IDLE
      if (k == 4) bus.proc_req = 4'b0000;
    end
    tick();
    chk("rr_idle_rd", 64'(bus.mem_read_req), 64'h0);

    // Timeout, processor 1, no ack
    bus.proc_addr[1] = 16'h0042;
    bus.proc_req     = 4'b0010;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      chk("to_rd_high", 64'(bus.mem_read_req), 64'h1);
      chk("to_no_err",  64'(bus.proc_err),     64'h0);
    end
    tick();
    bus.proc_req = 4'b0000;
    chk("to_rd_low", 64'(bus.mem_read_req), 64'h0);
    chk("to_err",    64'(bus.proc_err),     64'h2);
    chk("to_done",   64'(bus.proc_done),    64'h0);
    chk("to_rdata",  64'(bus.proc_rdata),   64'h0);
    tick();
    chk("to_err_off", 64'(bus.proc_err),    64'h0);

    // Late ack while IDLE is ignored
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk_quiet("late_ack");

    // Reset mid-BUSY: processor 3 read aborted, next grant to processor 0
    bus.proc_addr[0] = 16'h0100;
    bus.proc_addr[3] = 16'h0300;
    bus.proc_req     = 4'b1000;
    tick();                                   // cycle 1
    chk("rst_busy_addr", 64'(bus.mem_addr), 64'h0300);
    tick();                                   // cycle 2
    reset        = 1'b1;
    bus.proc_req = 4'b1001;
    tick();                                   // reset sampled
    reset = 1'b0;
    chk_quiet("rst_abort");
    tick();
    chk("rst_next_addr", 64'(bus.mem_addr),     64'h0100);
    chk("rst_next_rd",   64'(bus.mem_read_req), 64'h1);
    chk("rst_no_done",   64'(bus.proc_done),    64'h0);
    chk("rst_no_err",    64'(bus.proc_err),     64'h0);
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'hCAFE_0000;
    tick();
    bus.mem_ack  = 1'b0;
    bus.proc_req = 4'b1000;
    chk("rst_next_done",  64'(bus.proc_done),  64'h1);
    chk("rst_next_rdata", 64'(bus.proc_rdata), 64'hCAFE_0000);
    tick();
    tick();                                   // processor 3 now granted
    chk("rst_p3_addr", 64'(bus.mem_addr), 64'h0300);
    bus.mem_ack       = 1'b1;
    bus.mem_read_data = 32'h0000_0333;
    tick();
    bus.mem_ack  = 1'b0;
    bus.proc_req = 4'b0000;
    chk("rst_p3_done", 64'(bus.proc_done), 64'h8);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
